// File: rtl/psum_drain.sv
// Partial-sum accumulate/drain: sums MAC-array row vectors over a tile of beats, then
// drains each row saturated to DATA_WIDTH over valid/ready. Define PSUM_RELU_EN to drain negatives as 0.
module psum_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_ROWS = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [7:0]                      tile_cnt_i,
    input  logic                            res_valid_i,
    input  logic [DATA_WIDTH-1:0]           res_i [ARRAY_ROWS],
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [$clog2(ARRAY_ROWS)-1:0]   out_row_o,
    output logic                            out_last_o,
    output logic                            busy_o,
    output logic                            ovf_o
);

    localparam int ROW_W = $clog2(ARRAY_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_ROWS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q [ARRAY_ROWS];
    logic [7:0]                  beat_q, tile_q;
    logic [ROW_W-1:0]            row_q;
    logic                        ovf_q;
    logic                        final_beat, handshake, clamp;
    logic signed [ACC_WIDTH-1:0] row_val;
    logic [DATA_WIDTH-1:0]       row_sat;

    // Widened by one bit so a latched count of 255 still compares cleanly.
    assign final_beat = ({1'b0, beat_q} + 9'd1) == {1'b0, tile_q};
    assign handshake  = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ACCUM;
            end
            ACCUM: begin
                busy_o = 1'b1;
                if (res_valid_i && final_beat) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i && (row_q == LAST_ROW)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain value for the current row: optional ReLU, then clamp to the signed output range.
    always_comb begin
        row_val = acc_q[row_q];
`ifdef PSUM_RELU_EN
        if (row_val[ACC_WIDTH-1]) row_val = '0;
`endif
        clamp   = 1'b0;
        row_sat = row_val[DATA_WIDTH-1:0];
        if (row_val > SAT_MAX) begin
            clamp   = 1'b1;
            row_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (row_val < SAT_MIN) begin
            clamp   = 1'b1;
            row_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // NOTE: registers use non-blocking assignments so every update reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the accumulator array is reset explicitly because an aborted job must leave no stale sums.
            for (int r = 0; r < ARRAY_ROWS; r++) acc_q[r] <= '0;
            beat_q <= '0;
            tile_q <= '0;
            row_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        for (int r = 0; r < ARRAY_ROWS; r++) acc_q[r] <= '0;
                        beat_q <= '0;
                        row_q  <= '0;
                        ovf_q  <= 1'b0;
                        tile_q <= (tile_cnt_i == 8'd0) ? 8'd1 : tile_cnt_i;
                    end
                end
                ACCUM: begin
                    if (res_valid_i) begin
                        for (int r = 0; r < ARRAY_ROWS; r++)
                            acc_q[r] <= acc_q[r] + ACC_WIDTH'(signed'(res_i[r]));
                        beat_q <= beat_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                        if (clamp) ovf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced to zero outside DRAIN so idle/reset reads are clean.
    assign out_data_o = out_valid_o ? row_sat : '0;
    assign out_row_o  = row_q;
    assign out_last_o = out_valid_o && (row_q == LAST_ROW);
    assign ovf_o      = ovf_q | (handshake & clamp);

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: jobs are modelled with integer sums and pushed as expected
// rows; an independent monitor pops and compares on every output handshake.
module tb_psum_drain;

    localparam int DW   = 32;
    localparam int ROWS = 16;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [7:0]    tile_cnt_i;
    logic          res_valid_i;
    logic [DW-1:0] res_i [ROWS];
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [3:0]    out_row_o;
    logic          out_last_o;
    logic          busy_o;
    logic          ovf_o;

    psum_drain #(.DATA_WIDTH(DW), .ARRAY_ROWS(ROWS), .ACC_WIDTH(40)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .tile_cnt_i(tile_cnt_i),
        .res_valid_i(res_valid_i), .res_i(res_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_row_o(out_row_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          row;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_cycles = 0;
    int   row3_cycles = 0;
    int   ready_mode = 0;   // 0 random, 1 always ready, 2 one 5-cycle stall at row 3
    bit   job_ovf_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum per row, optional ReLU, clamp to signed 32-bit.
    function automatic logic [31:0] sat_ref(input longint v_in, output bit clamped);
        longint v = v_in;
        clamped = 1'b0;
`ifdef PSUM_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > SMAX) begin
            clamped = 1'b1;
            return 32'h7fffffff;
        end
        if (v < SMIN) begin
            clamped = 1'b1;
            return 32'h80000000;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] gen(input int pat, input int r);
        case (pat)
            0: return 32'(r + 1);
            1: return $urandom();
            2: case (r)
                   0: return 32'h7fffffff;
                   1: return 32'hfffffffb;
                   2: return 32'h80000000;
                   default: return 32'($urandom_range(0, 1000));
               endcase
            3: if (r == 0) return 32'h80000000;
               else return 32'($urandom_range(0, 200)) - 32'd100;
            default: return 32'($urandom_range(0, 2000)) - 32'd1000;
        endcase
    endfunction

    // Ready driver.
    initial begin
        bit stalled = 1'b0;
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ready_mode != 2) stalled = 1'b0;
            if (ready_mode == 2 && !stalled && out_valid_o && out_row_o == 4'd3) begin
                stalled     = 1'b1;
                out_ready_i = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready_i = 1'b1;
            end else if (ready_mode == 0) begin
                out_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready_i = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on handshakes and checks hold-stability under backpressure.
    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] hd;
        logic [3:0]  hr;
        logic        hl;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid_o, 1);
                    check("hold_data", out_data_o, hd);
                    check("hold_row", out_row_o, hr);
                    check("hold_last", out_last_o, hl);
                end
                if (out_valid_o) begin
                    valid_cycles++;
                    if (out_row_o == 4'd3) row3_cycles++;
                    if (out_ready_i) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: row=%0d data=0x%0h with no expected word",
                                     out_row_o, out_data_o);
                        end else begin
                            e = sb.pop_front();
                            check("out_data", out_data_o, e.data);
                            check("out_row", out_row_o, e.row);
                            check("out_last", out_last_o, e.last);
                        end
                        prev_stall = 1'b0;
                    end else begin
                        prev_stall = 1'b1;
                        hd = out_data_o;
                        hr = out_row_o;
                        hl = out_last_o;
                    end
                end else begin
                    prev_stall = 1'b0;
                    check("last_without_valid", out_last_o, 0);
                end
            end
        end
    end

    task automatic start_job(input int tile, input int pat, input bit b2b);
        int          n;
        longint      sums[ROWS];
        logic [31:0] flat[$];
        logic [31:0] v;
        bit          c, ovf_e, got;
        exp_t        e;
        n = (tile == 0) ? 1 : tile;
        for (int r = 0; r < ROWS; r++) sums[r] = 0;
        for (int i = 0; i < n; i++)
            for (int r = 0; r < ROWS; r++) begin
                v = gen(pat, r);
                flat.push_back(v);
                sums[r] += longint'(signed'(v));
            end
        got = 1'b0;
        if (b2b) begin
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (out_valid_o && out_ready_i && out_last_o) begin
                    got = 1'b1;
                    break;
                end
            end
            check("b2b_wait_last", got, 1);
            check("ovf_at_last_handshake", ovf_o, job_ovf_exp);
        end else begin
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (!busy_o) begin
                    got = 1'b1;
                    break;
                end
            end
            check("idle_before_start", got, 1);
        end
        ovf_e = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            e.row  = r;
            e.data = sat_ref(sums[r], c);
            e.last = (r == ROWS - 1);
            ovf_e |= c;
            sb.push_back(e);
        end
        job_ovf_exp = ovf_e;
        @(posedge clk); #1;
        start_i     = 1'b1;
        tile_cnt_i  = tile[7:0];
        res_valid_i = 1'b1;
        for (int r = 0; r < ROWS; r++) res_i[r] = $urandom();
        @(negedge clk);
        check("start_cycle_busy", busy_o, 0);
        check("start_cycle_valid", out_valid_o, 0);
        @(posedge clk); #1;
        start_i     = 1'b0;
        res_valid_i = 1'b0;
        tile_cnt_i  = 8'($urandom);
        @(negedge clk);
        check("busy_after_start", busy_o, 1);
        check("ovf_cleared", ovf_o, 0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                res_valid_i = 1'b0;
                for (int r = 0; r < ROWS; r++) res_i[r] = $urandom();
                @(negedge clk);
                check("no_valid_in_accum", out_valid_o, 0);
            end
            @(posedge clk); #1;
            res_valid_i = 1'b1;
            for (int r = 0; r < ROWS; r++) res_i[r] = flat[i*ROWS + r];
            @(negedge clk);
            check("no_valid_in_accum", out_valid_o, 0);
        end
        @(posedge clk); #1;
        res_valid_i = 1'b0;
        @(negedge clk);
        check("valid_after_final_beat", out_valid_o, 1);
    endtask

    // Drives ignored garbage on res_valid_i/res_i during DRAIN, optionally pulses start_i.
    task automatic wait_done(input bit pulse_start);
        bit got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            res_valid_i = 1'($urandom_range(0, 1));
            for (int r = 0; r < ROWS; r++) res_i[r] = $urandom();
            start_i    = pulse_start && (k == 0);
            tile_cnt_i = 8'd7;
            @(negedge clk);
            if (!busy_o) begin
                got = 1'b1;
                break;
            end
        end
        start_i     = 1'b0;
        res_valid_i = 1'b0;
        check("job_done", got, 1);
        check("ovf_final", ovf_o, job_ovf_exp);
        check("scoreboard_empty", sb.size(), 0);
        check("valid_low_when_idle", out_valid_o, 0);
        if (pulse_start)
            repeat (3) begin
                @(negedge clk);
                check("stays_idle", busy_o, 0);
            end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  v0, r0;
        bit  got, nb;
        rst = 1'b1;
        start_i = 1'b0;
        tile_cnt_i = 8'd0;
        res_valid_i = 1'b0;
        for (int r = 0; r < ROWS; r++) res_i[r] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_data", out_data_o, 0);
        check("rst_row", out_row_o, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic: rows 2,4,...,32 on consecutive cycles.
        ready_mode = 1;
        v0 = valid_cycles;
        start_job(2, 0, 1'b0);
        wait_done(1'b0);
        check("consecutive_drain_cycles", valid_cycles - v0, ROWS);

        // Backpressure at row 3 for 5 cycles.
        ready_mode = 2;
        r0 = row3_cycles;
        start_job(3, 4, 1'b0);
        wait_done(1'b0);
        check("row3_presented_cycles", row3_cycles - r0, 6);

        // Saturation (positive and negative), random backpressure from here on.
        ready_mode = 0;
        start_job(2, 2, 1'b0);
        wait_done(1'b0);
        start_job(2, 3, 1'b0);
        wait_done(1'b0);

        // tile_cnt_i = 0 behaves as one beat; then res_valid_i pulse in IDLE.
        start_job(0, 4, 1'b0);
        wait_done(1'b0);
        @(posedge clk); #1;
        res_valid_i = 1'b1;
        for (int r = 0; r < ROWS; r++) res_i[r] = $urandom();
        @(posedge clk); #1 res_valid_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_pulse_valid", out_valid_o, 0);
            check("idle_pulse_busy", busy_o, 0);
        end

        // start_i pulsed during DRAIN is ignored.
        start_job(1, 1, 1'b0);
        wait_done(1'b1);

        // Back-to-back jobs.
        start_job(3, 1, 1'b0);
        start_job(2, 4, 1'b1);
        wait_done(1'b0);

        // Reset mid-drain, then a fresh job.
        start_job(2, 1, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (out_valid_o && out_row_o == 4'd7) begin
                got = 1'b1;
                break;
            end
        end
        check("reached_row7", got, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_valid", out_valid_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_last", out_last_o, 0);
        check("abort_row", out_row_o, 0);
        check("abort_data", out_data_o, 0);
        check("abort_ovf", ovf_o, 0);
        repeat (3) begin
            @(negedge clk);
            check("no_output_after_abort", out_valid_o, 0);
        end
        job_ovf_exp = 1'b0;
        start_job(2, 0, 1'b0);
        wait_done(1'b0);

        // Random jobs, randomly chained back-to-back.
        nb = 1'b0;
        for (int j = 0; j < 8; j++) begin
            start_job($urandom_range(1, 6), ($urandom_range(0, 1) == 0) ? 1 : 4, nb);
            nb = 1'($urandom_range(0, 1));
            if (!nb) wait_done(1'b0);
        end
        if (nb) wait_done(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 The parameters SHALL be:
- DATA_WIDTH, default 32, width of each MAC row result and each output word.
- ARRAY_ROWS, default 16, number of row results per MAC-array beat.
- ACC_WIDTH, default 40, width of each internal partial-sum accumulator; must be at least DATA_WIDTH+1.

REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, input, 1, the single clock.
- rst, input, 1, synchronous, active-high reset.
- start_i, input, 1, starts a new accumulate/drain job.
- tile_cnt_i, input, 8, number of MAC-array beats to accumulate; sampled on start.
- res_valid_i, input, 1, the res_i vector is valid this cycle.
- res_i, input, DATA_WIDTH x ARRAY_ROWS (unpacked array), signed row results from the MAC array.
- out_valid_o, output, 1, out_data_o is valid.
- out_ready_i, input, 1, the consumer accepts the current word.
- out_data_o, output, DATA_WIDTH, signed drained row value.
- out_row_o, output, $clog2(ARRAY_ROWS), row index of out_data_o.
- out_last_o, output, 1, the current word is the final row of the job.
- busy_o, output, 1, asserted when the state is not IDLE.
- ovf_o, output, 1, sticky flag: at least one drained row saturated.

REQ-003 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 The state machine SHALL have exactly three states: IDLE, ACCUM and DRAIN.

REQ-005 In IDLE, when start_i=1: the block SHALL clear all accumulators, clear the beat counter, clear ovf_o, latch tile_cnt_i (a value of 0 is treated as 1), and enter ACCUM on the next cycle.

REQ-006 start_i SHALL be ignored in ACCUM and DRAIN.

REQ-007 In ACCUM, each cycle with res_valid_i=1 SHALL:
- add sign-extended res_i[r] into acc[r] for every r;
- increment the beat counter.

REQ-008 When the beat that makes the counter equal the latched count is accepted, the block SHALL enter DRAIN on the next cycle. out_valid_o SHALL rise one cycle after that final beat.

REQ-009 res_valid_i SHALL be ignored in IDLE and DRAIN; no accumulator changes.

REQ-010 Accumulator arithmetic SHALL be two's-complement at ACC_WIDTH and wrap silently internally.

REQ-011 In DRAIN, the block SHALL present rows in order 0 to ARRAY_ROWS-1, one per cycle in which out_valid_o=1 and out_ready_i=1.

REQ-012 out_data_o SHALL be acc[row] saturated to the signed DATA_WIDTH range: values above the maximum clamp to the maximum, and values below the minimum clamp to the minimum.

REQ-013 ovf_o SHALL be set in the handshake cycle of any row whose value was clamped, and SHALL remain set until the next accepted start.

REQ-014 While out_valid_o=1 and out_ready_i=0, out_data_o, out_row_o and out_last_o SHALL hold stable. out_valid_o SHALL never drop without a handshake.

REQ-015 out_last_o SHALL equal 1 exactly when out_row_o=ARRAY_ROWS-1 and out_valid_o=1.

REQ-016 On the handshake of the last row, the block SHALL return to IDLE and drive out_valid_o=0 on the next cycle. A start_i in that next cycle SHALL be accepted, so jobs can run back-to-back.

REQ-017 busy_o SHALL be 1 in ACCUM and DRAIN and 0 in IDLE.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL enter IDLE and drive:
- out_valid_o=0, out_last_o=0, busy_o=0, ovf_o=0;
- out_data_o=0, out_row_o=0;
- all accumulators and counters to 0.

REQ-019 rst SHALL override all other inputs, including start_i and an in-progress job in ACCUM or DRAIN. The aborted job SHALL produce no further output.

Configuration
REQ-020 With macro PSUM_RELU_EN defined, any negative accumulator value SHALL drain as 0 before saturation, and ovf_o SHALL be set only for positive clamping.

REQ-021 Without PSUM_RELU_EN, signed values SHALL drain unmodified apart from saturation (REQ-012).

Verification
REQ-022 Basic accumulate and drain: tile_cnt_i=2, two beats with res_i[r]=r+1 each, out_ready_i=1 -> rows 0..15 output 2,4,...,32 on consecutive cycles; out_last_o=1 only on row 15; ovf_o=0.

REQ-023 Backpressure: out_ready_i=0 for 5 cycles at row 3 -> row 3 data/index held for those 5 cycles; no row skipped or duplicated.

REQ-024 Saturation: tile_cnt_i=2, both beats with res_i[0]=0x7FFFFFFF -> row 0 outputs 0x7FFFFFFF and ovf_o=1. With PSUM_RELU_EN and res_i[1]=-5 -> row 1 outputs 0.

REQ-025 Ignored inputs: tile_cnt_i=0 -> the job completes after 1 beat. res_valid_i pulsed in IDLE, and start_i pulsed during DRAIN -> no state or output change.

REQ-026 Reset mid-job: rst=1 asserted in DRAIN at row 7 -> next cycle IDLE, out_valid_o=0, busy_o=0. A new job after reset drains fresh sums only.

REQ-027 Back-to-back jobs: start_i asserted in the cycle after the last handshake -> the new job is accepted, busy_o re-asserts, and the second job's results are independent of the first.
